// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and default width.
package serial_adder_pkg;

    localparam int unsigned SA_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CAPT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_piso_shift_reg.sv
// Parallel-in serial-out shift register: parallel load, shift right, LSB presented as a flop output.
module piso_shift_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             lsb
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {1'b0, q[WIDTH-1:1]};
        end
    end

    assign lsb = q[0];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Serial adder front end: streams operands LSB-first, collects the serial sum, done/ack handshake.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output (ovf).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             ser_a,
    output logic             ser_b,
    output logic             shift_control,
    output logic             add_clearb,
    input  logic             sum_in,
    input  logic             carry_in,
    output logic [WIDTH-1:0] result,
    output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             done,
    input  logic             ack
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic             load;
    logic             shift_en;
`ifdef SERIAL_ADDER_OVF_EN
    logic             c_msb;
`endif

    assign load     = (state == ST_IDLE) && start;
    assign shift_en = (state == ST_SHIFT);

    piso_shift_reg #(.WIDTH(WIDTH)) u_sa (
        .clk   (clk),
        .clear (clear),
        .load  (load),
        .shift (shift_en),
        .din   (a),
        .lsb   (ser_a)
    );

    piso_shift_reg #(.WIDTH(WIDTH)) u_sb (
        .clk   (clk),
        .clear (clear),
        .load  (load),
        .shift (shift_en),
        .din   (b),
        .lsb   (ser_b)
    );

    // Control FSM; every output is updated on the transition into the state that owns it.
    always_ff @(posedge clk) begin
        if (clear) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            shift_control <= 1'b0;
            add_clearb    <= 1'b1;
            result        <= '0;
            cout          <= 1'b0;
            done          <= 1'b0;
            count         <= '0;
            acc           <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            c_msb         <= 1'b0;
            ovf           <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_CLR;
                        busy       <= 1'b1;
                        add_clearb <= 1'b0;
                        count      <= '0;
                    end
                end
                ST_CLR: begin
                    state         <= ST_SHIFT;
                    add_clearb    <= 1'b1;
                    shift_control <= 1'b1;
                end
                ST_SHIFT: begin
                    acc   <= {sum_in, acc[WIDTH-1:1]};
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        state         <= ST_CAPT;
                        shift_control <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                        c_msb         <= carry_in;
`endif
                    end
                end
                ST_CAPT: begin
                    // carry_in now holds the carry out of the MSB add
                    result <= acc;
                    cout   <= carry_in;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf    <= c_msb ^ carry_in;
`endif
                    done   <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    if (ack) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
